// File: rtl/adder_arbiter_pkg.sv
// Shared defaults and tag type for the adder arbiter.
// The tag id width follows the default requester count.
package adder_arbiter_pkg;

   localparam int unsigned NUM_REQ_DEF = 4;
   localparam int unsigned ADD_LAT_DEF = 7;
   localparam int unsigned MAX_OUT_DEF = 4;
   localparam int unsigned ID_W        = $clog2(NUM_REQ_DEF);

   typedef struct packed {
      logic            vld;
      logic [ID_W-1:0] id;
   } tag_t;

endpackage

// File: rtl/adder_arbiter_if.sv
// Requester-side bus of the adder arbiter: per-requester operands in, tagged responses out.
interface adder_arbiter_if
   import adder_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ = NUM_REQ_DEF
);
   localparam int unsigned IdW = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ-1:0]       req_ready;
   logic [NUM_REQ-1:0][31:0] req_a;
   logic [NUM_REQ-1:0][31:0] req_b;
   logic [NUM_REQ-1:0]       req_ci;
   logic                     rsp_valid;
   logic [IdW-1:0]           rsp_id;
   logic [31:0]              rsp_s;
   logic                     rsp_co;

   modport master (
      output req_valid, req_a, req_b, req_ci,
      input  req_ready, rsp_valid, rsp_id, rsp_s, rsp_co
   );

   modport slave (
      input  req_valid, req_a, req_b, req_ci,
      output req_ready, rsp_valid, rsp_id, rsp_s, rsp_co
   );

endinterface

// File: rtl/adder_arbiter_rr_arbiter.sv
// Round-robin arbiter; the pointer names the highest-priority requester
// and moves past the winner only when the grant is taken.
module adder_arbiter_rr_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   localparam int unsigned IdW    = $clog2(NUM_REQ)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] eligible,
   input  logic               advance,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IdW-1:0]     gnt_idx,
   output logic               any_gnt
);

   logic [IdW-1:0] ptr_q;

   always_comb begin
      int unsigned idx;
      gnt     = '0;
      gnt_idx = '0;
      any_gnt = 1'b0;
      idx     = 0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         idx = 32'(ptr_q) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!any_gnt && eligible[idx]) begin
            any_gnt  = 1'b1;
            gnt[idx] = 1'b1;
            gnt_idx  = IdW'(idx);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= '0;
      end else if (advance) begin
         ptr_q <= (gnt_idx == IdW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
   end

endmodule

// File: rtl/adder_arbiter.sv
// Shares one free-running pipelined adder among NUM_REQ requesters, with a tag pipe
// aligned to the adder latency and per-requester credit counters.
module adder_arbiter
   import adder_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ = NUM_REQ_DEF,
   parameter int unsigned ADD_LAT = ADD_LAT_DEF,
   parameter int unsigned MAX_OUT = MAX_OUT_DEF
) (
   input  logic            clk,
   input  logic            rst,
   adder_arbiter_if.slave  bus,
   output logic [31:0]     add_a,
   output logic [31:0]     add_b,
   output logic            add_ci,
   input  logic [31:0]     add_s,
   input  logic            add_co,
   output logic            busy
);

   localparam int unsigned IdW    = $clog2(NUM_REQ);
   localparam logic [3:0]  MaxOut = 4'(MAX_OUT);

   logic [NUM_REQ-1:0] eligible;
   logic [NUM_REQ-1:0] gnt;
   logic [IdW-1:0]     gnt_idx;
   logic               any_gnt;
   logic               hs;

   logic [3:0] cnt_q [NUM_REQ];
   logic [3:0] cnt_d [NUM_REQ];
   tag_t       tag_q [ADD_LAT];
   tag_t       tail;

   logic           rsp_valid_q;
   logic [IdW-1:0] rsp_id_q;
   logic [31:0]    rsp_s_q;
   logic           rsp_co_q;

   always_comb begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         eligible[i] = bus.req_valid[i] && (cnt_q[i] < MaxOut);
      end
   end

   adder_arbiter_rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_rr (
      .clk      (clk),
      .rst      (rst),
      .eligible (eligible),
      .advance  (hs),
      .gnt      (gnt),
      .gnt_idx  (gnt_idx),
      .any_gnt  (any_gnt)
   );

   // Ready is forced low while reset is held so nothing is accepted into a clearing pipe.
   assign hs            = any_gnt & ~rst;
   assign bus.req_ready = rst ? '0 : gnt;

   always_comb begin
      add_a  = '0;
      add_b  = '0;
      add_ci = 1'b0;
      if (hs) begin
         add_a  = bus.req_a[gnt_idx];
         add_b  = bus.req_b[gnt_idx];
         add_ci = bus.req_ci[gnt_idx];
      end
   end

   assign tail = tag_q[ADD_LAT-1];

   // Issue and retire on the same requester cancel out.
   always_comb begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         cnt_d[i] = cnt_q[i];
         if (hs && gnt[i]) cnt_d[i] = cnt_d[i] + 4'd1;
         if (tail.vld && tail.id == ID_W'(i)) cnt_d[i] = cnt_d[i] - 4'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
         for (int unsigned k = 0; k < ADD_LAT; k++) tag_q[k] <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_s_q     <= '0;
         rsp_co_q    <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < NUM_REQ; i++) cnt_q[i] <= cnt_d[i];
         tag_q[0].vld <= hs;
         tag_q[0].id  <= hs ? ID_W'(gnt_idx) : '0;
         for (int unsigned k = 1; k < ADD_LAT; k++) tag_q[k] <= tag_q[k-1];
         rsp_valid_q <= tail.vld;
         if (tail.vld) begin
            rsp_id_q <= IdW'(tail.id);
            rsp_s_q  <= add_s;
            rsp_co_q <= add_co;
         end
      end
   end

   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_s     = rsp_s_q;
   assign bus.rsp_co    = rsp_co_q;

   always_comb begin
      busy = rsp_valid_q;
      for (int unsigned k = 0; k < ADD_LAT; k++) busy = busy | tag_q[k].vld;
   end

endmodule

// File: tb/tb_adder_arbiter.sv
// Randomized scoreboard bench for adder_arbiter with a behavioural adder and arbitration model.
module tb_adder_arbiter;
   import adder_arbiter_pkg::*;

   localparam int NR  = int'(NUM_REQ_DEF);
   localparam int LAT = int'(ADD_LAT_DEF);
   localparam int MO  = int'(MAX_OUT_DEF);
   localparam int IdW = $clog2(NR);

   typedef struct {
      int          id;
      logic [31:0] s;
      logic        co;
      int          due;
   } exp_t;

   typedef struct {
      int id;
      int issue;
      int rel;
   } fly_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] add_a, add_b, add_s;
   logic        add_ci, add_co, busy;

   adder_arbiter_if #(.NUM_REQ(NR)) bus ();

   adder_arbiter #(
      .NUM_REQ (NR),
      .ADD_LAT (LAT),
      .MAX_OUT (MO)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .bus    (bus),
      .add_a  (add_a),
      .add_b  (add_b),
      .add_ci (add_ci),
      .add_s  (add_s),
      .add_co (add_co),
      .busy   (busy)
   );

   always #5 clk = ~clk;

   // Free-running adder with LAT register stages, reset with the system.
   logic [32:0] add_pipe [LAT];
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < LAT; k++) add_pipe[k] <= '0;
      end else begin
         add_pipe[0] <= {1'b0, add_a} + {1'b0, add_b} + {32'b0, add_ci};
         for (int k = 1; k < LAT; k++) add_pipe[k] <= add_pipe[k-1];
      end
   end
   assign {add_co, add_s} = add_pipe[LAT-1];

   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   model_ptr = 0;
   exp_t exp_q[$];
   fly_t fly_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int outstanding(int id);
      int n = 0;
      foreach (fly_q[k]) if (fly_q[k].id == id && fly_q[k].rel > cyc) n++;
      return n;
   endfunction

   // Arbitration model: credits, round-robin choice, expected response and busy.
   always @(negedge clk) begin
      logic [NR-1:0] elig, exp_rdy;
      logic [32:0]   sum;
      logic          exp_busy;
      int            g;
      if (rst) begin
         checks++;
         if (bus.req_ready !== '0) begin
            errors++;
            $display("FAIL reset_ready: got %b want 0", bus.req_ready);
         end
         model_ptr = 0;
         fly_q.delete();
         exp_q.delete();
      end else begin
         while (fly_q.size() > 0 && fly_q[0].rel < cyc) void'(fly_q.pop_front());
         exp_busy = 1'b0;
         foreach (fly_q[k]) if (fly_q[k].issue < cyc && fly_q[k].rel >= cyc) exp_busy = 1'b1;
         checks++;
         if (busy !== exp_busy) begin
            errors++;
            $display("FAIL busy cyc %0d: got %b want %b", cyc, busy, exp_busy);
         end
         for (int i = 0; i < NR; i++) elig[i] = bus.req_valid[i] && (outstanding(i) < MO);
         g = -1;
         for (int k = 0; k < NR; k++) begin
            if (g < 0 && elig[(model_ptr + k) % NR]) g = (model_ptr + k) % NR;
         end
         exp_rdy = '0;
         if (g >= 0) exp_rdy[g] = 1'b1;
         checks++;
         if (bus.req_ready !== exp_rdy) begin
            errors++;
            $display("FAIL grant cyc %0d: got %b want %b", cyc, bus.req_ready, exp_rdy);
         end
         if (g >= 0) begin
            sum = {1'b0, bus.req_a[g]} + {1'b0, bus.req_b[g]} + {32'b0, bus.req_ci[g]};
            exp_q.push_back('{id: g, s: sum[31:0], co: sum[32], due: cyc + LAT + 1});
            fly_q.push_back('{id: g, issue: cyc, rel: cyc + LAT + 1});
            model_ptr = (g + 1) % NR;
         end
      end
   end

   // Response monitor.
   always @(negedge clk) begin
      exp_t e;
      logic exp_now;
      if (rst) begin
         checks++;
         if (bus.rsp_valid !== 1'b0 || bus.rsp_id !== '0 || bus.rsp_s !== '0 ||
             bus.rsp_co !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got vld=%b id=%0d s=%h co=%b busy=%b want all 0",
                     bus.rsp_valid, bus.rsp_id, bus.rsp_s, bus.rsp_co, busy);
         end
      end else begin
         exp_now = exp_q.size() > 0 && exp_q[0].due == cyc;
         checks++;
         if (bus.rsp_valid !== exp_now) begin
            errors++;
            $display("FAIL rsp_valid cyc %0d: got %b want %b", cyc, bus.rsp_valid, exp_now);
         end
         if (exp_now) begin
            e = exp_q.pop_front();
            if (bus.rsp_valid === 1'b1) begin
               checks++;
               if (bus.rsp_id !== IdW'(e.id) || bus.rsp_s !== e.s || bus.rsp_co !== e.co) begin
                  errors++;
                  $display("FAIL rsp cyc %0d: got id=%0d s=%h co=%b want id=%0d s=%h co=%b",
                           cyc, bus.rsp_id, bus.rsp_s, bus.rsp_co, e.id, e.s, e.co);
               end
            end
         end
      end
   end

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_reqs();
      bus.req_valid = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.req_ci    = '0;
   endtask

   task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic ci);
      bus.req_valid[i] = 1'b1;
      bus.req_a[i]     = a;
      bus.req_b[i]     = b;
      bus.req_ci[i]    = ci;
   endtask

   function automatic logic [31:0] rnd_op();
      case ($urandom_range(0, 7))
         0:       return 32'hFFFF_FFFF;
         1:       return 32'h7FFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'h0000_0000;
         default: return $urandom();
      endcase
   endfunction

   task automatic drive_mask(input logic [NR-1:0] mask);
      for (int i = 0; i < NR; i++) begin
         if (mask[i]) set_req(i, rnd_op(), rnd_op(), 1'($urandom_range(0, 1)));
         else bus.req_valid[i] = 1'b0;
      end
   endtask

   initial begin
      clear_reqs();
      rst = 1'b1;
      repeat (3) next();
      rst = 1'b0;
      while (cyc < 10) next();

      set_req(0, 32'd5, 32'd7, 1'b1);
      next();
      clear_reqs();
      repeat (12) next();

      set_req(1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
      next();
      clear_reqs();
      set_req(3, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
      next();
      clear_reqs();
      repeat (12) next();

      // Three ops in flight, then a one-cycle reset before any response returns.
      repeat (3) begin
         drive_mask(NR'(2));
         next();
      end
      clear_reqs();
      repeat (3) next();
      rst = 1'b1;
      next();
      rst = 1'b0;

      repeat (12) begin
         drive_mask('1);
         next();
      end
      clear_reqs();
      repeat (12) next();

      repeat (30) begin
         drive_mask(NR'(4));
         next();
      end
      clear_reqs();
      repeat (12) next();

      repeat (500) begin
         if ($urandom_range(0, 3) == 0) drive_mask('1);
         else drive_mask(NR'($urandom()));
         next();
      end
      clear_reqs();
      repeat (15) next();

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL leftover: got %0d pending responses want 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1);
   end

endmodule
